// File: rtl/isqrt_seq_responder.sv
// Bit-serial integer square root: one result bit per cycle, MSB first,
// fixed 16-cycle latency, back-to-back acceptance on the result cycle.
module isqrt_seq_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [15:0] y,
  output logic        busy,
  output logic        ovr_err
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [31:0] r_arg;
  logic [17:0] r_rem;
  logic [15:0] r_root;

  logic        w_last;
  logic        w_accept;
  logic        w_drop;
  logic [4:0]  w_shamt;
  logic [1:0]  w_pair;
  logic [17:0] w_src_rem;
  logic [15:0] w_src_root;
  logic [19:0] w_trial_rem;
  logic [19:0] w_trial;
  logic [17:0] w_rem_nxt;
  logic [15:0] w_root_nxt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (x_vld) w_state_nxt = CALC;
      CALC: if (r_cnt == 4'd15 && !x_vld) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state == CALC);
    w_last   = (r_state == CALC) && (r_cnt == 4'd15);
    w_accept = x_vld && ((r_state == IDLE) || w_last);
    w_drop   = x_vld && !w_accept;
  end

  // The first digit is resolved directly from x on the accepting edge, so the
  // remaining 15 digits finish one cycle early and y can be registered in time.
  always_comb begin
    w_shamt    = 5'd28 - {r_cnt, 1'b0};
    w_pair     = r_arg[w_shamt +: 2];
    w_src_rem  = r_rem;
    w_src_root = r_root;
    if (w_accept) begin
      w_pair     = x[31:30];
      w_src_rem  = '0;
      w_src_root = '0;
    end
    w_trial_rem = {w_src_rem, w_pair};
    w_trial     = {2'b00, w_src_root, 2'b01};
    if (w_trial_rem >= w_trial) begin
      w_rem_nxt  = 18'(w_trial_rem - w_trial);
      w_root_nxt = {w_src_root[14:0], 1'b1};
    end else begin
      w_rem_nxt  = w_trial_rem[17:0];
      w_root_nxt = {w_src_root[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_root  <= '0;
      y_vld   <= 1'b0;
      y       <= '0;
      ovr_err <= 1'b0;
    end else begin
      y_vld <= 1'b0;
      if (w_drop) ovr_err <= 1'b1;
      if (w_accept) begin
        r_arg  <= x;
        r_cnt  <= '0;
        r_rem  <= w_rem_nxt;
        r_root <= w_root_nxt;
      end else if (r_state == CALC) begin
        if (w_last) begin
          r_cnt <= '0;
        end else begin
          r_cnt  <= r_cnt + 4'd1;
          r_rem  <= w_rem_nxt;
          r_root <= w_root_nxt;
          if (r_cnt == 4'd14) begin
            y_vld <= 1'b1;
            y     <= w_root_nxt;
          end
        end
      end
    end
  end

endmodule
